// File: rtl/ctrl_progmem_pkg.sv
// Shared definitions for the controller program store: the loader state
// encoding and helpers that derive instruction width, load beat count and
// counter widths from the field-width parameters.
package ctrl_progmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        RUN  = 2'd3
    } state_t;

    // Instruction word: 2 opcode bits, vector id, two register addresses,
    // three RAM pointers.
    function automatic int calc_instr_width(input int vec_w, input int reg_w, input int data_w);
        return 2 + vec_w + 2 * reg_w + 3 * data_w;
    endfunction

    // Number of bus beats needed to carry one instruction word.
    function automatic int calc_beats(input int instr_w, input int bus_w);
        return (instr_w + bus_w - 1) / bus_w;
    endfunction

    // Width of a counter that counts 0..n-1; never narrower than one bit.
    function automatic int calc_count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_progmem_if.sv
// Load stream and fetch bus between the controller side and the program
// store. The master is the party that streams the program and issues
// fetches; the slave is the program store itself.
interface ctrl_progmem_if
    import ctrl_progmem_pkg::*;
#(
    parameter int BUS_WIDTH        = 8,
    parameter int INSTR_ADDR_WIDTH = 4,
    parameter int INSTR_WIDTH      = calc_instr_width(3, 3, 4)
) ();

    logic [BUS_WIDTH-1:0]        s_data;
    logic                        s_valid;
    logic                        s_ready;
    logic                        fetch;
    logic [INSTR_ADDR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0]      instr_word;

    modport master (
        output s_data, s_valid, fetch, pc,
        input  s_ready, instr_word
    );

    modport slave (
        input  s_data, s_valid, fetch, pc,
        output s_ready, instr_word
    );

endinterface

// File: rtl/ctrl_progmem_ram.sv
// Instruction RAM: one write port and one registered read port on the same
// clock. Contents are never cleared; the owner decides which words are valid.
module ctrl_progmem_ram #(
    parameter int WIDTH      = 23,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write and registered read share the clock; the read register holds
    // its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ctrl_progmem.sv
// Program store and loader for the sample-rate-converter controller.
// While prog is high, a byte-serial program is assembled into instruction
// words and written to the instruction RAM; while prog is low, fetches read
// the RAM with one cycle of latency, gated by the number of words loaded.
// Optional build macro PROGMEM_PARITY_EN: the first spare assembly bit is an
// even-parity bit checked as each word completes (sticky par_err).
module ctrl_progmem
    import ctrl_progmem_pkg::*;
#(
    parameter int VEC_ID_WIDTH       = 3,
    parameter int REGFILE_ADDR_WIDTH = 3,
    parameter int DATA_ADDR_WIDTH    = 4,
    parameter int INSTR_ADDR_WIDTH   = 4,
    parameter int BUS_WIDTH          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog,
    ctrl_progmem_if.slave             bus,
    output logic [INSTR_ADDR_WIDTH:0] prog_len,
    output logic                      load_err,
    output logic                      addr_err,
    output logic                      par_err
);

    localparam int INSTR_WIDTH = calc_instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH);
    localparam int BEATS       = calc_beats(INSTR_WIDTH, BUS_WIDTH);
    localparam int BEAT_W      = calc_count_width(BEATS);
    localparam int DEPTH       = 2 ** INSTR_ADDR_WIDTH;
    localparam int PTR_W       = INSTR_ADDR_WIDTH + 1;
`ifdef PROGMEM_PARITY_EN
    localparam int ASM_W       = INSTR_WIDTH + 1;
`else
    localparam int ASM_W       = INSTR_WIDTH;
`endif
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]  LAST_ADDR = PTR_W'(DEPTH - 1);

`ifdef PROGMEM_PARITY_EN
    // The parity bit lives in the spare assembly bits; without any spare
    // bit the configuration is meaningless.
    if (BEATS * BUS_WIDTH <= INSTR_WIDTH) begin : g_no_spare_bit
        $error("ctrl_progmem: parity needs a spare assembly bit above the instruction word");
    end
`endif

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [ASM_W-1:0]        asm_q, asm_d;
    logic                    s_ready_q, s_ready_d;
    logic                    hit_q, hit_d;
    logic [PTR_W-1:0]        prog_len_q, prog_len_d;
    logic                    load_err_q, load_err_d;
    logic                    addr_err_q, addr_err_d;
`ifdef PROGMEM_PARITY_EN
    logic                    par_err_q, par_err_d;
`endif

    logic                    accept;
    logic                    in_range;
    logic                    wr_en;
    logic                    rd_en;
    logic [INSTR_WIDTH-1:0]  ram_rdata;

    assign accept   = (state_q == LOAD) && bus.s_valid && s_ready_q;
    assign in_range = ({1'b0, bus.pc} < prog_len_q);

    // Loader FSM, beat assembler, write pointer and fetch handling.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        beat_d     = beat_q;
        asm_d      = asm_q;
        hit_d      = hit_q;
        prog_len_d = prog_len_q;
        load_err_d = load_err_q;
        addr_err_d = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
`ifdef PROGMEM_PARITY_EN
        par_err_d  = par_err_q;
`endif

        if (accept) begin
            for (int i = 0; i < ASM_W; i++) begin
                if ((i / BUS_WIDTH) == int'(beat_q)) begin
                    asm_d[i] = bus.s_data[i % BUS_WIDTH];
                end
            end
            if (beat_q == LAST_BEAT) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + 1'b1;
                beat_d = '0;
`ifdef PROGMEM_PARITY_EN
                par_err_d = par_err_q | (^asm_d);
`endif
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        case (state_q)
            IDLE, RUN: begin
                if (prog) begin
                    state_d    = LOAD;
                    wptr_d     = '0;
                    beat_d     = '0;
                    asm_d      = '0;
                    load_err_d = 1'b0;
                    prog_len_d = '0;
`ifdef PROGMEM_PARITY_EN
                    par_err_d  = 1'b0;
`endif
                end else if (state_q == IDLE) begin
                    state_d    = RUN;
                    prog_len_d = '0;
                end else if (bus.fetch) begin
                    rd_en      = in_range;
                    hit_d      = in_range;
                    addr_err_d = !in_range;
                end
            end
            LOAD: begin
                if (!prog) begin
                    state_d    = RUN;
                    prog_len_d = wptr_d;
                    load_err_d = (beat_d != '0);
                end else if (wr_en && (wptr_q == LAST_ADDR)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!prog) begin
                    state_d    = RUN;
                    prog_len_d = wptr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready_d = (state_d == LOAD);

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            beat_q     <= '0;
            asm_q      <= '0;
            s_ready_q  <= 1'b0;
            hit_q      <= 1'b0;
            prog_len_q <= '0;
            load_err_q <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef PROGMEM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            beat_q     <= beat_d;
            asm_q      <= asm_d;
            s_ready_q  <= s_ready_d;
            hit_q      <= hit_d;
            prog_len_q <= prog_len_d;
            load_err_q <= load_err_d;
            addr_err_q <= addr_err_d;
`ifdef PROGMEM_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    ctrl_progmem_ram #(
        .WIDTH      (INSTR_WIDTH),
        .ADDR_WIDTH (INSTR_ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_q[INSTR_ADDR_WIDTH-1:0]),
        .wr_data (asm_d[INSTR_WIDTH-1:0]),
        .rd_en   (rd_en),
        .rd_addr (bus.pc),
        .rd_data (ram_rdata)
    );

    // An out-of-range fetch or reset forces the output word to zero; the RAM
    // read register itself is never cleared.
    assign bus.instr_word = hit_q ? ram_rdata : '0;
    assign bus.s_ready    = s_ready_q;
    assign prog_len       = prog_len_q;
    assign load_err       = load_err_q;
    assign addr_err       = addr_err_q;
`ifdef PROGMEM_PARITY_EN
    assign par_err        = par_err_q;
`else
    assign par_err        = 1'b0;
`endif

endmodule
